// File: rtl/weight_bank_ctrl.sv
// weight_bank_ctrl: NUM_CH saturating weight levels adjusted through a cursor.
// Up/down buttons step the selected channel and auto-repeat while held.
// next_button advances the cursor. switch=0 freezes all state.
module weight_bank_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int WIDTH         = 3,
  parameter int MAX_LEVEL     = 5,
  parameter int DEFAULT_LEVEL = 0,
  parameter int REPEAT_DELAY  = 24,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        up_button,
  input  logic                        down_button,
  input  logic                        next_button,
  input  logic                        switch,
  output logic [$clog2(NUM_CH)-1:0]   sel,
  output logic [NUM_CH*WIDTH-1:0]     weights,
  output logic [WIDTH-1:0]            cur_weight,
  output logic                        changed
);

  localparam int SEL_W   = $clog2(NUM_CH);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [WIDTH-1:0] MAX_W       = WIDTH'(MAX_LEVEL);
  localparam logic [WIDTH-1:0] DEFAULT_W   = WIDTH'(DEFAULT_LEVEL);
  localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              dir_reg, dir_next;      // 0 = up, 1 = down
  logic              up_q_reg, down_q_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic              changed_reg;
  logic [WIDTH-1:0]  weight_reg [NUM_CH];

  logic              up_edge, down_edge, up_alone, down_alone, dir_held;
  logic              step, step_down;
  logic [WIDTH-1:0]  old_level, new_level;

  assign up_edge    = up_button & ~up_q_reg;
  assign down_edge  = down_button & ~down_q_reg;
  assign up_alone   = up_button & ~down_button;
  assign down_alone = down_button & ~up_button;
  assign dir_held   = dir_reg ? down_alone : up_alone;

  // Button history runs regardless of switch, so a button held across
  // reset or across switch rising produces no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_q_reg   <= 1'b1;
      down_q_reg <= 1'b1;
    end else begin
      up_q_reg   <= up_button;
      down_q_reg <= down_button;
    end
  end

  // Repeat FSM: decides when a step happens and in which direction.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    dir_next   = dir_reg;
    step       = 1'b0;
    step_down  = dir_reg;
    case (state_reg)
      IDLE: begin
        if (switch) begin
          if (up_edge && !down_button) begin
            step       = 1'b1;
            step_down  = 1'b0;
            dir_next   = 1'b0;
            count_next = '0;
            state_next = next_button ? IDLE : DELAY;
          end else if (down_edge && !up_button) begin
            step       = 1'b1;
            step_down  = 1'b1;
            dir_next   = 1'b1;
            count_next = '0;
            state_next = next_button ? IDLE : DELAY;
          end
        end
      end
      DELAY: begin
        if (!switch || next_button || !dir_held) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count_reg == DELAY_LAST) begin
          step       = 1'b1;
          count_next = '0;
          state_next = REPEAT;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      REPEAT: begin
        if (!switch || next_button || !dir_held) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count_reg == PERIOD_LAST) begin
          step       = 1'b1;
          count_next = '0;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // FSM state, repeat counter and direction register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      dir_reg   <= dir_next;
    end
  end

  // Saturating next level for the channel under the cursor.
  always_comb begin
    old_level = weight_reg[sel_reg];
    new_level = old_level;
    if (step_down) begin
      if (old_level != '0) new_level = old_level - 1'b1;
    end else begin
      if (old_level < MAX_W) new_level = old_level + 1'b1;
    end
  end

  // Per-channel level registers; only the channel under the (old) cursor steps.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      always_ff @(posedge clk) begin
        if (reset) begin
          weight_reg[gi] <= DEFAULT_W;
        end else if (step && (sel_reg == SEL_W'(gi))) begin
          weight_reg[gi] <= new_level;
        end
      end
      assign weights[gi*WIDTH +: WIDTH] = weight_reg[gi];
    end
  endgenerate

  // Cursor and change pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_reg     <= '0;
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= step && (new_level != old_level);
      if (switch && next_button) begin
        sel_reg <= (sel_reg == SEL_LAST) ? '0 : sel_reg + 1'b1;
      end
    end
  end

  assign sel        = sel_reg;
  assign cur_weight = weight_reg[sel_reg];
  assign changed    = changed_reg;

endmodule

// File: tb/tb_weight_bank_ctrl.sv
// Directed bench for weight_bank_ctrl with default parameters
// (4 channels x 3 bits, max level 5, delay 24, period 8).
module tb_weight_bank_ctrl;

  logic        clk = 1'b0;
  logic        reset, up_button, down_button, next_button, switch;
  logic [1:0]  sel;
  logic [11:0] weights;
  logic [2:0]  cur_weight;
  logic        changed;

  int checks_total  = 0;
  int checks_passed = 0;

  weight_bank_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .up_button   (up_button),
    .down_button (down_button),
    .next_button (next_button),
    .switch      (switch),
    .sel         (sel),
    .weights     (weights),
    .cur_weight  (cur_weight),
    .changed     (changed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] sel_exp [4];
    sel_exp[0] = 2'd1; sel_exp[1] = 2'd2; sel_exp[2] = 2'd3; sel_exp[3] = 2'd0;

    reset = 1'b1; up_button = 1'b0; down_button = 1'b0; next_button = 1'b0; switch = 1'b0;
    tick(); tick();
    check("rst_weights", 32'(weights), 32'h000);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_changed", 32'(changed), 32'd0);
    reset = 1'b0; switch = 1'b1;
    tick();

    // single up press on ch0
    up_button = 1'b1; tick();
    check("up1_weights", 32'(weights), 32'h001);
    check("up1_changed", 32'(changed), 32'd1);
    check("up1_sel", 32'(sel), 32'd0);
    up_button = 1'b0; tick();
    check("up1_changed_off", 32'(changed), 32'd0);

    // down back to 0, then down at 0 saturates
    down_button = 1'b1; tick();
    check("dn_weights", 32'(weights), 32'h000);
    check("dn_changed", 32'(changed), 32'd1);
    down_button = 1'b0; tick();
    down_button = 1'b1; tick();
    check("dn_sat_weights", 32'(weights), 32'h000);
    check("dn_sat_changed", 32'(changed), 32'd0);
    down_button = 1'b0; tick();

    // hold up 60 cycles from 0: steps at 0,24,32,40,48; 56 saturated
    up_button = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i == 0)  begin check("hold_0_w",  32'(weights), 32'h001); check("hold_0_c",  32'(changed), 32'd1); end
      if (i == 23) begin check("hold_23_w", 32'(weights), 32'h001); check("hold_23_c", 32'(changed), 32'd0); end
      if (i == 24) begin check("hold_24_w", 32'(weights), 32'h002); check("hold_24_c", 32'(changed), 32'd1); end
      if (i == 31) check("hold_31_w", 32'(weights), 32'h002);
      if (i == 32) check("hold_32_w", 32'(weights), 32'h003);
      if (i == 40) check("hold_40_w", 32'(weights), 32'h004);
      if (i == 48) begin check("hold_48_w", 32'(weights), 32'h005); check("hold_48_c", 32'(changed), 32'd1); end
      if (i == 56) begin check("hold_56_w", 32'(weights), 32'h005); check("hold_56_c", 32'(changed), 32'd0); end
    end
    up_button = 1'b0; tick();
    down_button = 1'b1; tick();
    check("dn_after_hold", 32'(weights), 32'h004);
    down_button = 1'b0; tick();

    // both buttons together: no step
    up_button = 1'b1; down_button = 1'b1; tick();
    check("both_weights", 32'(weights), 32'h004);
    check("both_changed", 32'(changed), 32'd0);
    tick();
    up_button = 1'b0; down_button = 1'b0; tick();
    check("both_release", 32'(weights), 32'h004);

    // cursor wrap
    for (int i = 0; i < 4; i++) begin
      next_button = 1'b1; tick();
      next_button = 1'b0;
      check("next_sel", 32'(sel), 32'(sel_exp[i]));
    end
    next_button = 1'b1; tick(); tick(); next_button = 1'b0;
    check("sel2", 32'(sel), 32'd2);
    check("cur_ch2_0", 32'(cur_weight), 32'd0);
    up_button = 1'b1; tick();
    check("ch2_up", 32'(weights), 32'h044);
    check("cur_ch2_1", 32'(cur_weight), 32'd1);
    up_button = 1'b0; tick();
    next_button = 1'b1; tick(); next_button = 1'b0;
    check("cur_ch3", 32'(cur_weight), 32'd0);
    next_button = 1'b1; tick(); next_button = 1'b0;
    check("cur_ch0", 32'(cur_weight), 32'd4);

    // button held while switch low, then switch raised while held
    switch = 1'b0; up_button = 1'b1; tick(); tick(); tick();
    check("sw0_weights", 32'(weights), 32'h044);
    check("sw0_changed", 32'(changed), 32'd0);
    next_button = 1'b1; tick(); next_button = 1'b0;
    check("sw0_sel_hold", 32'(sel), 32'd0);
    switch = 1'b1; tick(); tick(); tick();
    check("sw1_held_no_step", 32'(weights), 32'h044);
    up_button = 1'b0; tick();
    up_button = 1'b1; tick();
    check("sw1_repress", 32'(weights), 32'h045);
    up_button = 1'b0; tick();

    // into repeat on ch1, then next_button stops all stepping
    next_button = 1'b1; tick(); next_button = 1'b0;
    up_button = 1'b1; tick();
    check("rep_first", 32'(weights), 32'h04D);
    for (int i = 0; i < 24; i++) tick();
    check("rep_delay_step", 32'(weights), 32'h055);
    next_button = 1'b1; tick(); next_button = 1'b0;
    check("rep_next_sel", 32'(sel), 32'd2);
    for (int i = 0; i < 40; i++) tick();
    check("rep_next_frozen", 32'(weights), 32'h055);
    up_button = 1'b0; tick();

    // back to ch1 (2 -> 3 -> 0 -> 1), bring it to 1, then hold into REPEAT at 3
    for (int i = 0; i < 3; i++) begin
      next_button = 1'b1; tick(); next_button = 1'b0;
    end
    check("sel_back_1", 32'(sel), 32'd1);
    down_button = 1'b1; tick(); down_button = 1'b0; tick();
    check("ch1_down", 32'(weights), 32'h04D);
    up_button = 1'b1;
    for (int i = 0; i < 28; i++) tick();
    check("ch1_repeat3", 32'(weights), 32'h05D);

    // reset mid-hold
    reset = 1'b1; tick();
    check("midrst_weights", 32'(weights), 32'h000);
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_changed", 32'(changed), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("postrst_held", 32'(weights), 32'h000);
    up_button = 1'b0; tick();
    up_button = 1'b1; tick();
    check("postrst_repress", 32'(weights), 32'h001);
    check("postrst_changed", 32'(changed), 32'd1);
    up_button = 1'b0; tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/weight_bank_ctrl.md
Name: weight_bank_ctrl

Overview:
Parametrised multi-channel weight selector for the player's voice/mix path.
- Holds NUM_CH independent saturating levels in 0..MAX_LEVEL.
- A cursor picks the channel that the up/down buttons adjust.
- A held button auto-repeats after a delay.
- Sits between the button conditioning logic and the mixer, which reads the flattened weights bus.

Parameters:
NUM_CH, 4, number of weight channels (≥2)
WIDTH, 3, bits per weight; MAX_LEVEL < 2^WIDTH
MAX_LEVEL, 5, highest legal level
DEFAULT_LEVEL, 0, reset level of every channel; ≤ MAX_LEVEL
REPEAT_DELAY, 24, cycles from first step to first auto-repeat step (≥2)
REPEAT_PERIOD, 8, cycles between subsequent auto-repeat steps (≥1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
up_button  input  1  synchronised level; high while held
down_button  input  1  synchronised level; high while held
next_button  input  1  single-cycle pulse; advance cursor
switch  input  1  enable; low freezes all state
sel  output  $clog2(NUM_CH)  current cursor channel
weights  output  NUM_CH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
cur_weight  output  WIDTH  combinational slice of weights at sel
changed  output  1  registered one-cycle pulse when a weight value actually changed

Behaviour:
- Clocking and reset:
  - Single clock. Synchronous, active-high reset on `reset`.
  - Reset values: every channel = DEFAULT_LEVEL, sel=0, changed=0, FSM=IDLE, repeat counter=0.
  - Button history regs (up_q, down_q) reset to 1. A button held through reset does not step until it is released and pressed again.
- Edge detect:
  - up_q/down_q sample the buttons every cycle, regardless of switch.
  - Rising edge = btn & ~btn_q.
- Conflict: up_button and down_button both high is treated as no button. FSM goes to IDLE; no step.
- Step on channel sel:
  - up: weight+1 if weight < MAX_LEVEL, else unchanged.
  - down: weight-1 if weight > 0, else unchanged.
  - Saturating, never wraps.
  - changed is registered on the same edge the new value lands. It is 1 only if the value differs from the old one.
- Repeat FSM (states IDLE, DELAY, REPEAT; 1-bit dir register; counter wide enough for max(REPEAT_DELAY, REPEAT_PERIOD)):
  - IDLE: on a rising edge of exactly one button with switch=1: step, latch dir, counter=0, go to DELAY.
  - DELAY: if the dir button is still held alone, counter++. When counter==REPEAT_DELAY-1: step, counter=0, go to REPEAT.
  - REPEAT: counter++. When counter==REPEAT_PERIOD-1: step, counter=0.
  - Exit: in DELAY or REPEAT, release of the dir button, assertion of the other button, switch=0 or next_button=1 sends the FSM to IDLE with counter=0.
  - Timing: for a press first sampled at edge t and held, steps occur at edges t, t+REPEAT_DELAY, t+REPEAT_DELAY+k·REPEAT_PERIOD.
- Cursor:
  - next_button with switch=1 sets sel ← (sel+1) mod NUM_CH. NUM_CH-1 wraps to 0.
  - If a step and next_button coincide, the step applies to the old sel. The FSM still goes to IDLE, so a held button needs a re-press to act on the new channel.
- switch=0:
  - weights and sel hold; no steps; changed=0; FSM forced to IDLE.
  - Edge history still tracks, so a button already held when switch rises does not step.
- Reset mid-hold: all state returns to reset values on that edge; no step is applied on the reset edge.

Test Plan:
- Reset, then press up 1 cycle on ch0 with switch=1 → weights[2:0]=1 at next sample, changed pulse 1 cycle, other channels stay 0, sel=0.
- Hold up 60 cycles from level 0 → steps at t, t+24, t+32, t+40, t+48 reach 5. Edge t+56 gives no change and changed stays 0. Release then down 1 cycle → 4.
- Down pressed at level 0 → weight stays 0, changed=0. Up and down high together → no step, FSM IDLE.
- Pulse next_button 4 times → sel 1,2,3,0. Up on sel=2 → only bits [8:6] change; cur_weight tracks sel.
- Hold up with switch=0, then raise switch while still held → no step until release and re-press. Hold up into repeat, pulse next_button → no further steps on either channel.
- Assert reset during REPEAT with ch1=3 and button held → all channels 0, sel=0. After reset drops with button still held → no step until re-press.
